// File: rtl/rv_mul_ctrl_if.sv
// Request/response bundle between the execute-stage dispatcher and rv_mul_ctrl.
// A transfer happens on a clock edge where valid & ready are both high; once valid is
// raised its payload stays stable until that edge, and ready may depend on state only.
interface rv_mul_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [63:0]      req_op1;
    logic [63:0]      req_op2;
    logic             req_w;
    logic [TAG_W-1:0] req_tag;

    logic             resp_valid;
    logic             resp_ready;
    logic [63:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output req_valid, req_op1, req_op2, req_w, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag
    );

    modport slave (
        input  req_valid, req_op1, req_op2, req_w, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag
    );
endinterface

// File: rtl/rv_mul_ctrl.sv
// Issue/retire controller for the fixed-latency pipelined multiplier core: credit-based
// admission, a tag/op shadow pipeline aligned to the core, and a FWFT response FIFO.
module rv_mul_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 5
) (
    input  logic               clk,
    input  logic               rstn,
    rv_mul_ctrl_if.slave       bus,
    input  logic               flush_i,
    output logic [63:0]        core_op1_o,
    output logic [63:0]        core_op2_o,
    input  logic [63:0]        core_result_i,
    output logic               busy_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    function automatic logic [63:0] sext32(input logic [63:0] x);
        return {{32{x[31]}}, x[31:0]};
    endfunction

    logic [CW-1:0]    credits;
    logic             fire;
    logic             pop;
    logic             push;

    logic [MUL_LAT-1:0] sh_valid;
    logic [MUL_LAT-1:0] sh_w;
    logic [TAG_W-1:0]   sh_tag [MUL_LAT];

    logic [63:0]      fifo_data [DEPTH];
    logic [TAG_W-1:0] fifo_tag  [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [63:0]      retire_data;

    // Ready comes only from registered credits, so a same-cycle pop never frees a slot.
    assign bus.req_ready = (credits < CW'(DEPTH)) & ~flush_i;
    assign fire          = bus.req_valid & bus.req_ready;
    assign pop           = bus.resp_valid & bus.resp_ready;
    assign push          = sh_valid[MUL_LAT-1] & ~flush_i;
    assign busy_o        = (credits != '0);

    always_comb begin
        core_op1_o = '0;
        core_op2_o = '0;
        if (fire) begin
            core_op1_o = bus.req_w ? sext32(bus.req_op1) : bus.req_op1;
            core_op2_o = bus.req_w ? sext32(bus.req_op2) : bus.req_op2;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credits <= '0;
        end else if (flush_i) begin
            credits <= '0;
        end else if (fire && !pop) begin
            credits <= credits + CW'(1);
        end else if (!fire && pop) begin
            credits <= credits - CW'(1);
        end
    end

    // Shadow of the core pipeline; the last stage lines up with core_result_i.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_valid <= '0;
            sh_w     <= '0;
            for (int i = 0; i < MUL_LAT; i++) sh_tag[i] <= '0;
        end else begin
            for (int i = MUL_LAT - 1; i > 0; i--) begin
                sh_valid[i] <= sh_valid[i-1] & ~flush_i;
                sh_w[i]     <= sh_w[i-1];
                sh_tag[i]   <= sh_tag[i-1];
            end
            sh_valid[0] <= fire;
            sh_w[0]     <= bus.req_w;
            sh_tag[0]   <= bus.req_tag;
        end
    end

    assign retire_data = sh_w[MUL_LAT-1] ? sext32(core_result_i) : core_result_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_tag[i]  <= '0;
            end
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= retire_data;
                fifo_tag[wr_ptr]  <= sh_tag[MUL_LAT-1];
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    assign bus.resp_valid = (count != '0);
    assign bus.resp_data  = fifo_data[rd_ptr];
    assign bus.resp_tag   = fifo_tag[rd_ptr];

    // Credits make this unreachable; firing means admission accounting is broken.
    retire_into_full: assert property (@(posedge clk) disable iff (!rstn)
        !(push && count == CW'(DEPTH)));
endmodule

// File: tb/tb_rv_mul_ctrl.sv
// Bench for rv_mul_ctrl: behavioural 3-stage multiplier core, table vectors, streaming,
// back-pressure, flush and async-reset sequences, all checked through a tag/data scoreboard.
module tb_rv_mul_ctrl;
    localparam int TAG_W = 5;

    logic        clk;
    logic        rstn;
    logic        flush_i;
    logic [63:0] core_op1;
    logic [63:0] core_op2;
    logic [63:0] core_result;
    logic        busy;

    rv_mul_ctrl_if #(.TAG_W(TAG_W)) bus ();

    rv_mul_ctrl #(.MUL_LAT(3), .DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .bus           (bus),
        .flush_i       (flush_i),
        .core_op1_o    (core_op1),
        .core_op2_o    (core_op2),
        .core_result_i (core_result),
        .busy_o        (busy)
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-in: three register stages, product truncated to 64 bits.
    logic [63:0] prod;
    logic [63:0] cp0, cp1, cp2;
    assign prod = core_op1 * core_op2;
    always @(posedge clk) begin
        cp0 <= prod;
        cp1 <= cp0;
        cp2 <= cp1;
    end
    assign core_result = cp2;

    int n_vec;
    int n_err;
    int n_resp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [63:0] x);
        return {{32{x[31]}}, x[31:0]};
    endfunction

    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic w);
        logic [63:0] p;
        if (w) begin
            p = sx(a) * sx(b);
            return sx(p);
        end
        return a * b;
    endfunction

    // Scoreboard
    logic [TAG_W+63:0] exp_q[$];

    always @(negedge clk) begin
        logic [TAG_W+63:0] e;
        if (!rstn) begin
            exp_q.delete();
        end else begin
            if (bus.resp_valid && bus.resp_ready) begin
                n_resp++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_resp: got tag %0d data %h, required no response",
                             bus.resp_tag, bus.resp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_tag", 64'(bus.resp_tag), 64'(e[TAG_W+63:64]));
                    check("sb_data", bus.resp_data, e[63:0]);
                end
            end
            if (bus.req_valid && bus.req_ready)
                exp_q.push_back({bus.req_tag, model(bus.req_op1, bus.req_op2, bus.req_w)});
            if (flush_i) exp_q.delete();
        end
    end

    typedef struct {
        logic [63:0]      op1;
        logic [63:0]      op2;
        logic             w;
        logic [TAG_W-1:0] tag;
        logic [63:0]      c1;
        logic [63:0]      c2;
        logic [63:0]      data;
    } vec_t;

    vec_t vecs[8];

    // Driver tasks
    task automatic issue_one(input vec_t v);
        int lat;
        bit got;
        @(posedge clk); #1;
        bus.req_op1   = v.op1;
        bus.req_op2   = v.op2;
        bus.req_w     = v.w;
        bus.req_tag   = v.tag;
        bus.req_valid = 1'b1;
        @(negedge clk);
        check("vec_req_ready", 64'(bus.req_ready), 64'd1);
        check("vec_core_op1", core_op1, v.c1);
        check("vec_core_op2", core_op2, v.c2);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.resp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL vec_timeout: got no resp_valid, required one for tag %0d", v.tag);
        end else begin
            check("vec_latency", 64'(lat), 64'd4);
            check("vec_data", bus.resp_data, v.data);
            check("vec_tag", 64'(bus.resp_tag), 64'(v.tag));
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        check({name, "_idle"}, 64'(idle), 64'd1);
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base;
        int n_f;
        int seen;
        bit ok;

        vecs[0] = '{64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 5'd5,
                    64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1] = '{64'h1234_5678_8000_0000, 64'h2, 1'b1, 5'd6,
                    64'hFFFF_FFFF_8000_0000, 64'h2, 64'h0};
        vecs[2] = '{64'h4000_0000, 64'h2, 1'b1, 5'd7,
                    64'h4000_0000, 64'h2, 64'hFFFF_FFFF_8000_0000};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd8,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
        vecs[4] = '{64'h1_0000_0000, 64'h1_0000_0000, 1'b0, 5'd9,
                    64'h1_0000_0000, 64'h1_0000_0000, 64'h0};
        vecs[5] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 5'd10,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
        vecs[6] = '{64'h0000_FFFF_0001_0000, 64'h1_0000, 1'b1, 5'd11,
                    64'h1_0000, 64'h1_0000, 64'h0};
        vecs[7] = '{64'h1234, 64'h10, 1'b0, 5'd31,
                    64'h1234, 64'h10, 64'h1_2340};

        n_vec = 0;
        n_err = 0;
        n_resp = 0;
        rstn = 1'b0;
        flush_i = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op1 = '0;
        bus.req_op2 = '0;
        bus.req_w = 1'b0;
        bus.req_tag = '0;
        bus.resp_ready = 1'b1;

        #2;
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_resp_data", bus.resp_data, 64'd0);
        check("rst_resp_tag", 64'(bus.resp_tag), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_core_op1", core_op1, 64'd0);
        check("rst_core_op2", core_op2, 64'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        for (int i = 0; i < 8; i++) issue_one(vecs[i]);
        wait_idle("table");

        // Streaming: each request held until accepted.
        base = n_resp;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            bus.req_op1 = {$urandom(), $urandom()};
            bus.req_op2 = {$urandom(), $urandom()};
            bus.req_w = 1'($urandom_range(0, 1));
            bus.req_tag = TAG_W'($urandom_range(0, 31));
            bus.req_valid = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (bus.req_ready) break;
                if (k == 9) ok = 1'b0;
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("stream_accepted", 64'(ok), 64'd1);
        wait_idle("stream");
        check("stream_resp_count", 64'(n_resp - base), 64'd20);

        // Back-pressure: four credits then stall.
        bus.resp_ready = 1'b0;
        n_f = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            bus.req_op1 = {$urandom(), $urandom()};
            bus.req_op2 = {$urandom(), $urandom()};
            bus.req_w = 1'($urandom_range(0, 1));
            bus.req_tag = TAG_W'(n_f);
            bus.req_valid = 1'b1;
            @(negedge clk);
            if (bus.req_ready) n_f++;
        end
        check("bp_fires", 64'(n_f), 64'd4);
        check("bp_ready_low", 64'(bus.req_ready), 64'd0);
        check("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
        check("bp_head_tag", 64'(bus.resp_tag), 64'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_pop_cycle", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        check("bp_ready_after_pop", 64'(bus.req_ready), 64'd1);
        wait_idle("bp");

        // Flush with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.req_op1 = {$urandom(), $urandom()};
            bus.req_op2 = {$urandom(), $urandom()};
            bus.req_w = 1'b0;
            bus.req_tag = TAG_W'(20 + i);
            bus.req_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        flush_i = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_resp_valid", 64'(bus.resp_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check("flush_no_resp", 64'(seen), 64'd0);
        issue_one(vecs[0]);
        wait_idle("flush");

        // Asynchronous reset between edges with two operations in flight.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            bus.req_op1 = 64'h55 + 64'(i);
            bus.req_op2 = 64'h3;
            bus.req_w = 1'b0;
            bus.req_tag = TAG_W'(12 + i);
            bus.req_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("arst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("arst_req_ready", 64'(bus.req_ready), 64'd1);
        check("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check("arst_no_stale", 64'(seen), 64'd0);
        issue_one(vecs[2]);
        wait_idle("arst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
